// File: rtl/adder_arbiter_if.sv
// Request/response bundle between the adder arbiter and its clients.
// Latency: none (wires only); the arbiter defines all timing.
// Backpressure: req_ready grants one requester; rsp_ready stalls the held result.
interface adder_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 6,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_x;
    logic [NREQ*WIDTH-1:0] req_y;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH:0]        rsp_sum;
    logic [IDW-1:0]        rsp_id;
    logic                  busy;

    // Arbiter side
    modport slave (
        input  req_valid, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_id, busy
    );

    // Client / environment side
    modport master (
        output req_valid, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_id, busy
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder among NREQ requesters; returns sum + requester id.
// Latency: grant at edge N, rsp_valid from the cycle after edge N+1 (2 cycles); one result per 2 cycles peak.
// Backpressure: result held in RESP until rsp_ready; no grants while the result is stalled.
// Optional: define ADDER_ARBITER_STATS_EN to add stat_ops / stat_stall counters.
module adder_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 6,
    parameter int IDW   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    adder_arbiter_if.slave  bus
`ifdef ADDER_ARBITER_STATS_EN
    ,
    output logic [15:0]     stat_ops,
    output logic [15:0]     stat_stall
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_ptr;
    logic [WIDTH-1:0] r_op_x;
    logic [WIDTH-1:0] r_op_y;
    logic [IDW-1:0]   r_op_id;
    logic [WIDTH:0]   r_sum;
    logic [IDW-1:0]   r_id;

    logic             w_accept_ok;
    logic             w_found;
    logic [IDW-1:0]   w_gnt;
    logic [IDW-1:0]   w_scan;
    logic             w_xfer;
    logic [WIDTH-1:0] w_gnt_x;
    logic [WIDTH-1:0] w_gnt_y;

    // A new request may be taken when idle, or when the held result leaves this cycle
    assign w_accept_ok = (r_state == S_IDLE) || ((r_state == S_RESP) && bus.rsp_ready);
    assign w_xfer      = w_accept_ok && w_found;

    // Round-robin search starting one past the last granted requester
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_scan  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_scan = IDW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && bus.req_valid[w_scan]) begin
                w_found = 1'b1;
                w_gnt   = w_scan;
            end
        end
    end

    // One-hot grant plus the winner's operand slices
    always_comb begin
        bus.req_ready = '0;
        w_gnt_x       = '0;
        w_gnt_y       = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt == IDW'(i)) begin
                bus.req_ready[i] = w_xfer;
                w_gnt_x          = bus.req_x[i*WIDTH +: WIDTH];
                w_gnt_y          = bus.req_y[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state: EXEC is always a single cycle; RESP may chain straight into EXEC
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_xfer) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_RESP;
            S_RESP: begin
                if (w_xfer)             w_state_nxt = S_EXEC;
                else if (bus.rsp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Operand capture on transfer, adder result registered during EXEC
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr   <= IDW'(NREQ - 1);
            r_op_x  <= '0;
            r_op_y  <= '0;
            r_op_id <= '0;
            r_sum   <= '0;
            r_id    <= '0;
        end else begin
            if (w_xfer) begin
                r_ptr   <= w_gnt;
                r_op_x  <= w_gnt_x;
                r_op_y  <= w_gnt_y;
                r_op_id <= w_gnt;
            end
            if (r_state == S_EXEC) begin
                r_sum <= {1'b0, r_op_x} + {1'b0, r_op_y};
                r_id  <= r_op_id;
            end
        end
    end

    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_sum   = r_sum;
    assign bus.rsp_id    = r_id;
    assign bus.busy      = (r_state != S_IDLE);

`ifdef ADDER_ARBITER_STATS_EN
    logic [15:0] r_stat_ops;
    logic [15:0] r_stat_stall;

    // Completed responses wrap; stall cycles saturate
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_ops   <= '0;
            r_stat_stall <= '0;
        end else begin
            if (bus.rsp_valid && bus.rsp_ready)
                r_stat_ops <= r_stat_ops + 16'd1;
            if (bus.rsp_valid && !bus.rsp_ready && (r_stat_stall != 16'hFFFF))
                r_stat_stall <= r_stat_stall + 16'd1;
        end
    end

    assign stat_ops   = r_stat_ops;
    assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboarded bench for adder_arbiter: directed scenarios followed by random traffic.
// Reference model predicts grants and results at transaction level; a monitor pops results.
// Honours ADDER_ARBITER_STATS_EN to also check the statistics counters.
module tb_adder_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 6;
    localparam int IDW   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adder_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

`ifdef ADDER_ARBITER_STATS_EN
    logic [15:0] stat_ops;
    logic [15:0] stat_stall;
`endif

    adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ADDER_ARBITER_STATS_EN
        ,
        .stat_ops   (stat_ops),
        .stat_stall (stat_stall)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int id;
        int sum;
    } exp_t;
    exp_t sb_q[$];

    // ---------------- reference model (transaction level) ----------------
    int cyc = 0;
    bit m_have;
    int m_valid_from;
    int m_last;
    int m_ops;
    int m_stall;
    bit m_exp_valid;
    bit m_accept;
    int m_win;
    int m_idx;
    int m_x;
    int m_y;
    logic [NREQ-1:0] m_exp_ready;

    // Model decides what the DUT must show this cycle and what the next edge does
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_have  = 1'b0;
            m_last  = NREQ - 1;
            m_ops   = 0;
            m_stall = 0;
            sb_q.delete();
        end else begin
            m_exp_valid = m_have && (cyc >= m_valid_from);
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_exp_valid));
            chk("busy", 32'(bus.busy), 32'(m_have));
`ifdef ADDER_ARBITER_STATS_EN
            chk("stat_ops", 32'(stat_ops), 32'(m_ops));
            chk("stat_stall", 32'(stat_stall), 32'(m_stall));
`endif
            m_accept = !m_have || (m_exp_valid && bus.rsp_ready);
            m_win = -1;
            for (int k = 1; k <= NREQ; k++) begin
                m_idx = (m_last + k) % NREQ;
                if (m_win < 0 && bus.req_valid[m_idx]) m_win = m_idx;
            end
            m_exp_ready = '0;
            if (m_accept && m_win >= 0) m_exp_ready[m_win] = 1'b1;
            chk("req_ready", 32'(bus.req_ready), 32'(m_exp_ready));

            if (m_exp_valid && bus.rsp_ready) begin
                m_have = 1'b0;
                m_ops  = (m_ops + 1) % 65536;
            end
            if (m_exp_valid && !bus.rsp_ready && m_stall < 65535) m_stall++;
            if (m_accept && m_win >= 0) begin
                m_x = int'(bus.req_x[m_win*WIDTH +: WIDTH]);
                m_y = int'(bus.req_y[m_win*WIDTH +: WIDTH]);
                m_have       = 1'b1;
                m_valid_from = cyc + 2;
                m_last       = m_win;
                sb_q.push_back('{id: m_win, sum: m_x + m_y});
            end
        end
    end

    // ---------------- monitor ----------------
    // Presented result must equal the oldest expected entry; pop on handshake
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_rsp", 32'(sb_q.size()), 32'd1);
            end else begin
                chk("rsp_sum", 32'(bus.rsp_sum), 32'(sb_q[0].sum));
                chk("rsp_id", 32'(bus.rsp_id), 32'(sb_q[0].id));
                if (bus.rsp_ready) void'(sb_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int x, input int y);
        bus.req_x[i*WIDTH +: WIDTH] = WIDTH'(x);
        bus.req_y[i*WIDTH +: WIDTH] = WIDTH'(y);
    endtask

    // Lone request from requester i; checks grant pulse and the result two cycles on
    task automatic do_single(input int i, input int x, input int y, input int exp_sum);
        logic [NREQ-1:0] onehot;
        onehot = '0;
        onehot[i] = 1'b1;
        set_op(i, x, y);
        bus.req_valid = onehot;
        #1 chk("single_grant", 32'(bus.req_ready), 32'(onehot));
        step(1);
        bus.req_valid = '0;
        #1 chk("single_grant_off", 32'(bus.req_ready), 32'd0);
        step(1);
        #1;
        chk("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("single_rsp_sum", 32'(bus.rsp_sum), 32'(exp_sum));
        chk("single_rsp_id", 32'(bus.rsp_id), 32'(i));
        step(2);
        chk("single_back_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.rsp_ready = 1'b1;
        step(3);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_rsp_sum", 32'(bus.rsp_sum), 32'd0);
        chk("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
        rst_n = 1'b1;
        step(1);

        // Single request and adder corner values
        do_single(1, 5, 9, 14);
        do_single(0, 63, 63, 126);
        do_single(0, 0, 0, 0);

        // Round-robin from reset with everyone requesting
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 10 * i);
        bus.req_valid = '1;
        for (int i = 0; i < 10; i++) begin
            #1 chk("rr_order", 32'(bus.req_ready), (i % 2 == 0) ? (32'd1 << ((i / 2) % NREQ)) : 32'd0);
            step(1);
        end
        bus.req_valid = '0;
        step(3);

        // Backpressure: result held for five stalled cycles, grant on release
        set_op(2, 33, 44);
        bus.req_valid = 4'b0100;
        bus.rsp_ready = 1'b0;
        step(1);
        bus.req_valid = 4'b1001;
        step(1);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_no_grant", 32'(bus.req_ready), 32'd0);
            chk("bp_sum_hold", 32'(bus.rsp_sum), 32'd77);
            chk("bp_id_hold", 32'(bus.rsp_id), 32'd2);
            step(1);
        end
`ifdef ADDER_ARBITER_STATS_EN
        chk("bp_stat_stall", 32'(stat_stall), 32'd5);
`endif
        bus.rsp_ready = 1'b1;
        #1 chk("bp_release_grant", 32'(bus.req_ready), 32'b1000);
        step(1);
        bus.req_valid = '0;
        step(4);

        // Operands changed after the transfer must not leak into the result
        set_op(3, 10, 20);
        bus.req_valid = 4'b1000;
        step(1);
        set_op(3, 50, 7);
        bus.req_valid = '0;
        step(1);
        #1 chk("hold_sum", 32'(bus.rsp_sum), 32'd30);
        step(3);

        // Reset while a result waits in RESP
        bus.req_valid = '1;
        bus.rsp_ready = 1'b0;
        step(2);
        #1 chk("rst_mid_in_resp", 32'(bus.rsp_valid), 32'd1);
        rst_n = 1'b0;
        step(1);
        chk("rst_mid_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        #1 chk("rst_mid_first_grant", 32'(bus.req_ready), 32'd1);
        step(1);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            bus.req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++)
                set_op(i, int'($urandom_range(0, (1 << WIDTH) - 1)),
                          int'($urandom_range(0, (1 << WIDTH) - 1)));
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            step(1);
        end

        // Drain and confirm every expected result appeared
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        step(6);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
